// File: rtl/bt_fhs_pkg.sv
// Shared types and constants for the FHS payload receive controller.
// States, packet geometry, error codes and a saturating increment.
package bt_fhs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_RECV,
    ST_CHECK
  } fhs_state_e;

  localparam logic [3:0] TYPE_FHS = 4'b0010;

  localparam int FHS_INFO_BITS = 144;
  localparam int FHS_CRC_BITS  = 16;
  localparam int FHS_PKT_BITS  =
    FHS_INFO_BITS + FHS_CRC_BITS;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CRC     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_ABORT   = 2'd3;

  function automatic logic [7:0] sat_inc(
    input logic [7:0] v
  );
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/fhs_rx_timer.sv
// Cycle counter with clear and enable; flags when LIMIT-1 is reached.
// Stops counting at the limit so it never wraps.
module fhs_rx_timer #(
  parameter int LIMIT = 1800
) (
  input  logic clk_6M,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(LIMIT);

  logic [W-1:0] cnt;

  assign expired = (cnt == W'(LIMIT - 1));

  always_ff @(posedge clk_6M) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/fhs_rx_ctrl.sv
// FHS payload receive sequencer: start, bit count, CRC verdict.
// Commit pulse latches captured FHS fields downstream.
module fhs_rx_ctrl
  import bt_fhs_pkg::*;
#(
  parameter int TIMEOUT = 1800
) (
  input  logic       clk_6M,
  input  logic       rst,
  input  logic       fhs_en,
  input  logic       hdr_done_p,
  input  logic       hdr_ok,
  input  logic [3:0] hdr_type,
  input  logic       daten,
  input  logic       py_datvalid_p,
  input  logic       crc_ok,
  input  logic       rx_abort,
  output logic       dec_py_st_p,
  output logic       dec_py_period,
  output logic       rxfhs,
  output logic       crc_init_p,
  output logic       fhs_busy,
  output logic [7:0] bitcnt,
  output logic       fhs_commit_p,
  output logic       fhs_err_p,
  output logic [1:0] fhs_err_code,
  output logic [7:0] fhs_ok_cnt,
  output logic [7:0] fhs_err_cnt
);

  fhs_state_e state;

  logic       tmr_exp;
  logic       hdr_hit;
  logic       bit_p;
  logic       last_bit;
  logic       abort_hit;
  logic       fail;
  logic [1:0] fail_code;

  fhs_rx_timer #(
    .LIMIT (TIMEOUT)
  ) u_timer (
    .clk_6M  (clk_6M),
    .rst     (rst),
    .clr     (state == ST_START),
    .en      (state == ST_RECV),
    .expired (tmr_exp)
  );

  assign bit_p = daten & py_datvalid_p;

  assign hdr_hit = (state == ST_IDLE)
    & hdr_done_p & hdr_ok & fhs_en
    & (hdr_type == TYPE_FHS);

  assign abort_hit = rx_abort
    & (state != ST_IDLE);

  assign last_bit = (state == ST_RECV)
    & bit_p & ~rx_abort
    & (bitcnt == 8'(FHS_PKT_BITS - 1));

  // Abort outranks the last bit, which outranks timeout.
  assign fail = abort_hit
    | ((state == ST_RECV) & ~last_bit & tmr_exp)
    | ((state == ST_CHECK) & ~crc_ok);

  assign fail_code = abort_hit ? ERR_ABORT
    : (state == ST_CHECK) ? ERR_CRC
    : ERR_TIMEOUT;

  always_ff @(posedge clk_6M) begin
    if (rst) begin
      state         <= ST_IDLE;
      dec_py_st_p   <= 1'b0;
      crc_init_p    <= 1'b0;
      dec_py_period <= 1'b0;
      rxfhs         <= 1'b0;
      fhs_busy      <= 1'b0;
      bitcnt        <= 8'd0;
      fhs_commit_p  <= 1'b0;
      fhs_err_p     <= 1'b0;
      fhs_err_code  <= ERR_NONE;
      fhs_ok_cnt    <= 8'd0;
      fhs_err_cnt   <= 8'd0;
    end else begin
      dec_py_st_p  <= 1'b0;
      crc_init_p   <= 1'b0;
      fhs_commit_p <= 1'b0;
      fhs_err_p    <= 1'b0;
      if (hdr_hit) begin
        bitcnt <= 8'd0;
      end else if (last_bit ||
          (state == ST_RECV && bit_p
           && !rx_abort)) begin
        bitcnt <= bitcnt + 8'd1;
      end
      if (fail) begin
        state         <= ST_IDLE;
        fhs_busy      <= 1'b0;
        dec_py_period <= 1'b0;
        rxfhs         <= 1'b0;
        fhs_err_p     <= 1'b1;
        fhs_err_code  <= fail_code;
        fhs_err_cnt   <= sat_inc(fhs_err_cnt);
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (hdr_hit) begin
              state        <= ST_START;
              dec_py_st_p  <= 1'b1;
              crc_init_p   <= 1'b1;
              fhs_busy     <= 1'b1;
              fhs_err_code <= ERR_NONE;
            end
          end
          ST_START: begin
            state         <= ST_RECV;
            dec_py_period <= 1'b1;
            rxfhs         <= 1'b1;
          end
          ST_RECV: begin
            if (last_bit) begin
              state         <= ST_CHECK;
              dec_py_period <= 1'b0;
              rxfhs         <= 1'b0;
            end
          end
          ST_CHECK: begin
            state        <= ST_IDLE;
            fhs_busy     <= 1'b0;
            fhs_commit_p <= 1'b1;
            fhs_ok_cnt   <= sat_inc(fhs_ok_cnt);
          end
        endcase
      end
    end
  end

endmodule
